// File: rtl/spwm_duty_capture.sv
`default_nettype none
//==============================================================================
// Module      : spwm_duty_capture
// Description : Three-channel SPWM receiver/monitor. Each input is
//               synchronised, its rising edges are detected, and the high time
//               and period of every carrier cycle are measured in clk_int
//               cycles. A channel that shows no rising edge for TIMEOUT cycles
//               is flagged as stuck, and the line level at that moment is
//               recorded.
// Ports       : clk_int          - system clock, rising edge
//               reset            - asynchronous reset, active low
//               spwm_in[2:0]     - asynchronous SPWM inputs (bit0 = phase 1)
//               high_1..3        - last completed high time per channel
//               period_1..3      - last completed period per channel
//               valid[2:0]       - one-cycle strobe, new high/period latched
//               stuck[2:0]       - per-channel stuck level flag
//               stuck_lvl[2:0]   - synchronised level when stuck was set
// Revision    : 1.0 - initial release
//==============================================================================
module spwm_duty_capture #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic             clk_int,
   input  logic             reset,
   input  logic [2:0]       spwm_in,
   output logic [CNT_W-1:0] high_1,
   output logic [CNT_W-1:0] high_2,
   output logic [CNT_W-1:0] high_3,
   output logic [CNT_W-1:0] period_1,
   output logic [CNT_W-1:0] period_2,
   output logic [CNT_W-1:0] period_3,
   output logic [2:0]       valid,
   output logic [2:0]       stuck,
   output logic [2:0]       stuck_lvl
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MEAS  = 2'd1;
   localparam logic [1:0] S_STUCK = 2'd2;

   //---------------------------------------------------------------------------
   // Input path: two-stage synchroniser followed by a previous-sample register
   // used for rising-edge detection.
   //---------------------------------------------------------------------------
   logic [2:0] meta_q;
   logic [2:0] sync_q;
   logic [2:0] prev_q;
   logic [2:0] rise_w;

   always_ff @(posedge clk_int or negedge reset) begin
      if (!reset) begin
         meta_q <= 3'b000;
         sync_q <= 3'b000;
         prev_q <= 3'b000;
      end else begin
         meta_q <= spwm_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_w = sync_q & ~prev_q;

   // Per-channel results gathered here so the flat output ports can be driven
   // from a single place.
   logic [CNT_W-1:0] high_w   [3];
   logic [CNT_W-1:0] period_w [3];
   logic [2:0]       valid_w;
   logic [2:0]       stuck_w;
   logic [2:0]       stuck_lvl_w;

   //---------------------------------------------------------------------------
   // Per-channel measurement engine (identical for every phase).
   //---------------------------------------------------------------------------
   for (genvar g = 0; g < 3; g++) begin : g_ch
      logic [1:0]       state_q;
      logic [1:0]       state_d;
      logic [CNT_W-1:0] pcnt_q;
      logic [CNT_W-1:0] pcnt_d;
      logic [CNT_W-1:0] hcnt_q;
      logic [CNT_W-1:0] hcnt_d;
      logic [CNT_W-1:0] icnt_q;
      logic [CNT_W-1:0] icnt_d;
      logic [CNT_W-1:0] high_q;
      logic [CNT_W-1:0] high_d;
      logic [CNT_W-1:0] period_q;
      logic [CNT_W-1:0] period_d;
      logic             valid_q;
      logic             valid_d;
      logic             stuck_q;
      logic             stuck_d;
      logic             stuck_lvl_q;
      logic             stuck_lvl_d;

      // State register
      always_ff @(posedge clk_int or negedge reset) begin
         if (!reset) begin
            state_q <= S_IDLE;
         end else begin
            state_q <= state_d;
         end
      end

      // Next-state logic. A rise always takes priority over a timeout, so a
      // period of exactly TIMEOUT cycles is still a valid measurement.
      always_comb begin
         state_d = state_q;
         case (state_q)
            S_IDLE: begin
               if (rise_w[g]) begin
                  state_d = S_MEAS;
               end else if (icnt_q == TIMEOUT_C) begin
                  state_d = S_STUCK;
               end
            end
            S_MEAS: begin
               if (!rise_w[g] && (pcnt_q == TIMEOUT_C)) begin
                  state_d = S_STUCK;
               end
            end
            S_STUCK: begin
               if (rise_w[g]) begin
                  state_d = S_MEAS;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Output and datapath logic
      always_comb begin
         pcnt_d      = pcnt_q;
         hcnt_d      = hcnt_q;
         icnt_d      = icnt_q;
         high_d      = high_q;
         period_d    = period_q;
         valid_d     = 1'b0;
         stuck_d     = stuck_q;
         stuck_lvl_d = stuck_lvl_q;

         // Counters restart on every rise. They only run while measuring and
         // stop at TIMEOUT, which bounds them well inside CNT_W and keeps
         // hcnt from ever overtaking pcnt.
         if (rise_w[g]) begin
            pcnt_d = ONE_C;
            hcnt_d = ONE_C;
         end else if ((state_q == S_MEAS) && (pcnt_q != TIMEOUT_C)) begin
            pcnt_d = pcnt_q + ONE_C;
            if (sync_q[g]) begin
               hcnt_d = hcnt_q + ONE_C;
            end
         end

         // Idle watchdog covers a line that never toggles after reset.
         if ((state_q == S_IDLE) && (icnt_q != TIMEOUT_C)) begin
            icnt_d = icnt_q + ONE_C;
         end

         // A rise in MEAS closes the current carrier cycle; the counters still
         // hold their pre-reload values here. A rise in IDLE or STUCK only
         // arms the channel because no full period has been observed.
         if ((state_q == S_MEAS) && rise_w[g]) begin
            high_d   = hcnt_q;
            period_d = pcnt_q;
            valid_d  = 1'b1;
         end

         if ((state_d == S_STUCK) && (state_q != S_STUCK)) begin
            stuck_d     = 1'b1;
            stuck_lvl_d = sync_q[g];
         end

         if ((state_q == S_STUCK) && rise_w[g]) begin
            stuck_d = 1'b0;
         end
      end

      // Datapath registers
      always_ff @(posedge clk_int or negedge reset) begin
         if (!reset) begin
            pcnt_q      <= '0;
            hcnt_q      <= '0;
            icnt_q      <= '0;
            high_q      <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
         end else begin
            pcnt_q      <= pcnt_d;
            hcnt_q      <= hcnt_d;
            icnt_q      <= icnt_d;
            high_q      <= high_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            stuck_q     <= stuck_d;
            stuck_lvl_q <= stuck_lvl_d;
         end
      end

      assign high_w[g]      = high_q;
      assign period_w[g]    = period_q;
      assign valid_w[g]     = valid_q;
      assign stuck_w[g]     = stuck_q;
      assign stuck_lvl_w[g] = stuck_lvl_q;
   end

   //---------------------------------------------------------------------------
   // Output mapping
   //---------------------------------------------------------------------------
   assign high_1    = high_w[0];
   assign high_2    = high_w[1];
   assign high_3    = high_w[2];
   assign period_1  = period_w[0];
   assign period_2  = period_w[1];
   assign period_3  = period_w[2];
   assign valid     = valid_w;
   assign stuck     = stuck_w;
   assign stuck_lvl = stuck_lvl_w;

endmodule
`default_nettype wire

// File: tb/tb_spwm_duty_capture.sv
`default_nettype none
//==============================================================================
// Module      : tb_spwm_duty_capture
// Description : Scoreboard testbench for spwm_duty_capture. Stimulus tasks push
//               the expected (high, period) pair of each completed carrier
//               cycle; a negedge monitor pops and compares whenever a valid
//               bit is seen.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_spwm_duty_capture;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 1000;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             s0, s1, s2;
   logic [2:0]       spwm;
   logic [CNT_W-1:0] high_1, high_2, high_3;
   logic [CNT_W-1:0] period_1, period_2, period_3;
   logic [2:0]       valid, stuck, stuck_lvl;

   assign spwm = {s2, s1, s0};

   always #5 clk = ~clk;

   spwm_duty_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_int   (clk),
      .reset     (reset_n),
      .spwm_in   (spwm),
      .high_1    (high_1),
      .high_2    (high_2),
      .high_3    (high_3),
      .period_1  (period_1),
      .period_2  (period_2),
      .period_3  (period_3),
      .valid     (valid),
      .stuck     (stuck),
      .stuck_lvl (stuck_lvl)
   );

   typedef struct {
      int h;
      int p;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   function automatic void push_exp(int ch, int h, int p);
      exp_t e;
      e.h = h;
      e.p = p;
      case (ch)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic int qsize(int ch);
      case (ch)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   // Monitor side of the scoreboard
   function automatic void mon_ch(int ch, int h, int p);
      exp_t e;
      if (qsize(ch) == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_valid_ch%0d: got valid with high=%0d period=%0d, expected no valid",
                  ch + 1, h, p);
         return;
      end
      case (ch)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      chk($sformatf("high_ch%0d", ch + 1), h, e.h);
      chk($sformatf("period_ch%0d", ch + 1), p, e.p);
   endfunction

   always @(negedge clk) begin
      if (valid[0]) mon_ch(0, int'(high_1), int'(period_1));
      if (valid[1]) mon_ch(1, int'(high_2), int'(period_2));
      if (valid[2]) mon_ch(2, int'(high_3), int'(period_3));
   end

   // Inputs change 2 time units after the active edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ch(int ch, logic v);
      case (ch)
         0:       s0 = v;
         1:       s1 = v;
         default: s2 = v;
      endcase
   endtask

   // n periods of h high / l low. The first rise only arms the channel, so
   // period k-1 is completed by the rise that starts period k.
   task automatic drive_wave(int ch, int h, int l, int n, bit push);
      for (int k = 0; k < n; k++) begin
         if (push && (k >= 1)) push_exp(ch, h, h + l);
         set_ch(ch, 1'b1);
         repeat (h) tick();
         set_ch(ch, 1'b0);
         repeat (l) tick();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      s0 = 1'b0;
      s1 = 1'b0;
      s2 = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
   endtask

   task automatic check_drained(string tag);
      repeat (8) tick();
      chk({tag, "_pending_ch1"}, q0.size(), 0);
      chk({tag, "_pending_ch2"}, q1.size(), 0);
      chk({tag, "_pending_ch3"}, q2.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset_n = 1'b0;
      s0 = 1'b0;
      s1 = 1'b0;
      s2 = 1'b0;

      // Reset held while inputs toggle: everything must stay at zero
      repeat (2) @(posedge clk);
      #2;
      for (int i = 0; i < 20; i++) begin
         s0 = i[0];
         s1 = i[1];
         s2 = ~i[0];
         tick();
      end
      chk("rst_valid", valid, 0);
      chk("rst_stuck", stuck, 0);
      chk("rst_stuck_lvl", stuck_lvl, 0);
      chk("rst_high", high_1 | high_2 | high_3, 0);
      chk("rst_period", period_1 | period_2 | period_3, 0);
      s0 = 1'b0;
      s1 = 1'b0;
      s2 = 1'b0;
      tick();
      reset_n = 1'b1;
      // A single rise after reset only arms the channel
      drive_wave(0, 5, 5, 1, 1'b0);
      repeat (10) tick();
      chk("arm_high1", high_1, 0);
      chk("arm_period1", period_1, 0);

      // Fixed 30/70 duty on channel 1
      do_reset();
      drive_wave(0, 30, 70, 5, 1'b1);
      check_drained("duty");
      chk("duty_hold_high1", high_1, 30);
      chk("duty_hold_period1", period_1, 100);

      // Three phases simultaneously
      do_reset();
      fork
         drive_wave(0, 10, 40, 4, 1'b1);
         drive_wave(1, 25, 25, 4, 1'b1);
         drive_wave(2, 40, 10, 4, 1'b1);
      join
      check_drained("phases");

      // Minimum period on channel 2
      do_reset();
      drive_wave(1, 1, 1, 10, 1'b1);
      check_drained("minper");
      chk("minper_stuck2", stuck[1], 0);

      // Stuck low on channel 3 after running 50/50
      do_reset();
      drive_wave(2, 50, 50, 3, 1'b1);
      k = 100;
      repeat (TIMEOUT - 110) begin
         tick();
         k++;
      end
      chk("stuck_low_early", stuck[2], 0);
      for (int w = 0; w < 40; w++) begin
         if (stuck[2]) break;
         tick();
         k++;
      end
      chk("stuck_low_set", stuck[2], 1);
      chk("stuck_low_latency_min", (k >= TIMEOUT) ? 1 : 0, 1);
      chk("stuck_low_latency_max", (k <= TIMEOUT + 6) ? 1 : 0, 1);
      chk("stuck_low_lvl", stuck_lvl[2], 0);
      chk("stuck_low_hold_high3", high_3, 50);
      chk("stuck_low_hold_period3", period_3, 100);
      // Resume: first rise clears stuck without a valid
      fork
         drive_wave(2, 50, 50, 3, 1'b1);
         begin
            repeat (10) tick();
            chk("resume_stuck_clear", stuck[2], 0);
         end
      join
      check_drained("resume");

      // Channel 1 held high from reset (others idle low)
      do_reset();
      s0 = 1'b1;
      repeat (TIMEOUT + 20) tick();
      chk("stuck_high_flags", stuck, 3'b111);
      chk("stuck_high_lvl", stuck_lvl, 3'b001);
      chk("stuck_high_no_meas", high_1, 0);

      // Asynchronous reset in the middle of a measurement
      do_reset();
      drive_wave(0, 30, 70, 3, 1'b1);
      push_exp(0, 30, 100);
      s0 = 1'b1;
      repeat (15) tick();
      chk("midrst_pre_high1", high_1, 30);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midrst_high1", high_1, 0);
      chk("midrst_period1", period_1, 0);
      chk("midrst_valid", valid, 0);
      chk("midrst_stuck", stuck, 0);
      chk("midrst_pending_ch1", q0.size(), 0);
      s0 = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      drive_wave(0, 30, 70, 3, 1'b1);
      check_drained("rearm");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spwm_duty_capture.md
Name: spwm_duty_capture

Overview:
- Three-channel SPWM receiver/monitor: the inverse of the three-phase SPWM generator.
- Samples spwm_1..spwm_3 (the generator outputs, or pins looped back from the gate drivers) on the internal clock.
- Measures each channel's high time and period per carrier cycle in clk_int cycles; pulses a per-channel valid strobe.
- Flags stuck channels. Used for on-board self-check and motor-drive fault detection.

Parameters:
- CNT_W, 16, width of the high/period measurement counters.
- TIMEOUT, 50000, cycles without a rising edge before a channel is declared stuck; must satisfy 2 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk_int  input  1  single system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is externally synchronised.
- spwm_in  input  3  asynchronous SPWM inputs; bit0 = phase 1, bit1 = phase 2, bit2 = phase 3.
- high_1, high_2, high_3  output  CNT_W each  last completed high time per channel.
- period_1, period_2, period_3  output  CNT_W each  last completed period per channel.
- valid  output  3  one-cycle strobe per channel: new high/period pair latched.
- stuck  output  3  per-channel stuck flag; level, not a pulse.
- stuck_lvl  output  3  synchronised input level at the time stuck was set.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; synchronisers, counters and FSMs cleared; FSMs in IDLE.
- Input path, per bit:
  - 2-FF synchroniser, then a previous-sample register.
  - rise = sync & ~prev.
  - Input-to-rise latency: 3 cycles. The bench compares values only, not absolute edge timing.
- Channels are fully independent; identical logic is instantiated three times.
- Per-channel counters:
  - pcnt (period): on rise cycle, load 1; otherwise increment.
  - hcnt (high): on rise cycle, load 1; otherwise increment while sync=1, hold while sync=0.
- Per-channel FSM:
  - IDLE:
    - Waiting for the first rise.
    - rise -> MEAS (counters loaded, no valid).
    - pcnt not running in IDLE; stuck check uses a separate idle counter with the same TIMEOUT.
  - MEAS:
    - On rise: latch period_x <= pcnt and high_x <= hcnt (values before reload); valid[x]=1 in the following cycle for exactly one cycle; reload counters; stay in MEAS.
    - If pcnt reaches TIMEOUT with no rise -> STUCK.
  - STUCK:
    - stuck[x]=1 and stuck_lvl[x]=sync, captured on entry.
    - high/period outputs hold their last values.
    - On rise: clear stuck, load counters -> MEAS. No valid on this edge (the period is invalid).
  - IDLE timeout: idle counter reaches TIMEOUT -> STUCK. Covers a line held at 0 or 1 from reset.
- Result rules:
  - Square wave with H high and L low cycles: high=H, period=H+L. Requires H>=1, L>=1; minimum period=2.
  - high <= period always.
  - A constant-high line (no rise) never yields valid.
- Width rule: pcnt never exceeds TIMEOUT, so no wrap-around can occur; high cannot exceed pcnt.
- Simultaneous events:
  - rise in the same cycle pcnt reaches TIMEOUT: rise wins; stay in MEAS, no stuck.
  - Rises on several channels in the same cycle: independent valid bits may assert together.
- Reset mid-operation: immediate return to reset values. The first post-reset rise only arms the channel; the first valid needs a second rise.

Test Plan:
- Reset: hold reset=0 while toggling inputs -> all outputs 0, valid never asserts; release, first rise per channel gives no valid.
- Fixed duty: ch1 repeated 30 high / 70 low -> from the second rise onward, valid[0] pulses every 100 cycles with high_1=30, period_1=100.
- Three phases: ch1 10/40, ch2 25/25, ch3 40/10 -> (high, period) = (10,50), (25,50), (40,50); valid bits independent, each exactly one cycle wide.
- Minimum period: ch2 alternating 1 high / 1 low -> high_2=1, period_2=2, valid every 2 cycles, stuck=0.
- Stuck low (TIMEOUT=1000): ch3 running 50/50, then held 0 -> stuck[2]=1 and stuck_lvl[2]=0 exactly 1000 cycles after the last rise; last high/period held.
  - Resume toggling -> stuck clears on the first rise; next valid one period later.
- Stuck high from reset plus mid-measurement reset: ch1 held 1 after reset -> stuck[0]=1, stuck_lvl[0]=1 after TIMEOUT.
  - Assert reset mid-period on a running channel -> outputs 0 asynchronously, re-arm required before the next valid.
